trig_period_meter: RTL and testbench
====================================

TRIG_PERIOD_METER -- requirements
Module: trig_period_meter

Interface
REQ-001 SHALL have parameter N, default 10: expected trigger period in CLK50MHZ cycles.
REQ-002 SHALL have parameter TOL, default 1: allowed deviation, in cycles, from N for a period to count as a match.
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive matching periods required to assert locked.
REQ-004 SHALL have parameter TIMEOUT, default 4*N: cycle count at which a missing trigger is declared; constraint TIMEOUT > N+TOL.
REQ-005 SHALL have port CLK50MHZ  input  1  sole clock, all logic on posedge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port trig_in  input  1  single-cycle trigger pulse, synchronous to CLK50MHZ.
REQ-008 SHALL have port period  output  W  last measured interval in cycles, W = log2(TIMEOUT)+1.
REQ-009 SHALL have port period_valid  output  1  one-cycle strobe marking a new period value.
REQ-010 SHALL have port locked  output  1  high while the last LOCK_CNT periods all matched.
REQ-011 SHALL have port timeout  output  1  high from timeout detection until the next trigger.

Function
REQ-012 SHALL implement FSM states WAIT_FIRST, MEASURE, TIMED_OUT.
REQ-013 WAIT_FIRST: on trig_in -> MEASURE, count <= 1; no period_valid.
REQ-014 MEASURE: cycle without trig_in -> count <= count+1; cycle with trig_in -> period <= count, period_valid <= 1 on the next edge, count <= 1.
REQ-015 Triggers exactly N cycles apart SHALL yield period = N.
REQ-016 Latency: period and period_valid registered, visible the cycle after the closing trigger.
REQ-017 MEASURE with count == TIMEOUT and no trig_in SHALL go to TIMED_OUT: timeout <= 1, locked <= 0, match count <= 0.
REQ-018 Simultaneous trig_in and count == TIMEOUT: trigger wins; period = TIMEOUT reported, no timeout.
REQ-019 count SHALL never exceed TIMEOUT and SHALL never wrap.
REQ-020 TIMED_OUT: on trig_in -> MEASURE, count <= 1, timeout <= 0; no period_valid for the aborted interval.
REQ-021 A period in N-TOL..N+TOL inclusive SHALL increment the match count, saturating at LOCK_CNT.
REQ-022 locked SHALL rise on the edge where the match count reaches LOCK_CNT, coincident with that period_valid.
REQ-023 An out-of-window period SHALL clear the match count and drop locked coincident with its period_valid.
REQ-024 period SHALL hold its last value between strobes.

Reset
REQ-025 While RST == 0 at a posedge: state <= WAIT_FIRST; count, match count, period, period_valid, locked, timeout <= 0.
REQ-026 Reset mid-measurement SHALL discard the interval; the first trigger after release only starts a measurement.

Structure
REQ-027 FSM state encodings and the log2 constant function SHALL live in the shared clock utilities include, reused by the clock divider blocks.
REQ-028 The match counter plus locked flag SHALL be one sub-module, lock_tracker (inputs: period_valid strobe, in-window flag, timeout clear).
REQ-029 Interval counter, FSM and window compare SHALL stay in trig_period_meter.

Verification (N=10, TOL=1, LOCK_CNT=4, TIMEOUT=40)
REQ-030 Triggers every 10 cycles x6 -> 5 period_valid strobes, each with period=10; locked rises with the 4th strobe.
REQ-031 While locked, one 13-cycle interval -> period=13 and locked=0 in the same cycle; four further 10-cycle intervals relock.
REQ-032 Intervals 9, 11, 9, 11 -> locked after the 4th; one further 8-cycle interval -> locked=0.
REQ-033 No trigger for 40 cycles after a trigger -> timeout=1, locked=0, no period_valid; next trigger clears timeout with no strobe; trigger 10 cycles later -> period=10.
REQ-034 Trigger exactly 40 cycles after the previous one -> period=40 strobe, timeout stays 0, match count cleared.
REQ-035 RST=0 mid-interval while locked -> all outputs 0 at the next edge; after release, first trigger gives no strobe and the second, 10 cycles later, gives period=10.

Source files
------------

// File: rtl/trig_period_meter_pkg.sv
// Shared clock utilities: meter FSM state encoding and a constant log2
// helper, also reused by the clock divider blocks.
package trig_period_meter_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      TIMED_OUT  = 2'd2
   } meter_state_e;

   // floor(log2(v)) for v >= 1; returns 0 for v <= 1
   function automatic int flog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((v >> i) != 0) r = i;
      return r;
   endfunction

endpackage

// File: rtl/trig_period_meter_if.sv
// Trigger input and measurement results of the trigger period meter.
interface trig_period_meter_if #(
   parameter int W = 6
);
   logic         trig_in;
   logic [W-1:0] period;
   logic         period_valid;
   logic         locked;
   logic         timeout;

   modport master (output trig_in, input period, period_valid, locked, timeout);
   modport slave  (input trig_in, output period, period_valid, locked, timeout);
endinterface

// File: rtl/trig_period_meter_lock_tracker.sv
// Counts consecutive in-window periods and flags lock once LOCK_CNT is reached.
module lock_tracker #(
   parameter int LOCK_CNT = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic strobe_i,
   input  logic in_win_i,
   input  logic clr_i,
   output logic locked_o
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0] MMAX = MW'(LOCK_CNT);

   logic [MW-1:0] match_q, match_d;
   logic          locked_q, locked_d;

   always_comb begin
      match_d  = match_q;
      locked_d = locked_q;
      if (clr_i) begin
         match_d  = '0;
         locked_d = 1'b0;
      end else if (strobe_i) begin
         if (in_win_i) begin
            match_d  = (match_q == MMAX) ? MMAX : match_q + 1'b1;
            locked_d = (int'(match_q) >= LOCK_CNT - 1);
         end else begin
            match_d  = '0;
            locked_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         match_q  <= '0;
         locked_q <= 1'b0;
      end else begin
         match_q  <= match_d;
         locked_q <= locked_d;
      end
   end

   assign locked_o = locked_q;
endmodule

// File: rtl/trig_period_meter.sv
// Measures the interval between trigger pulses, detects missing triggers and
// reports lock when consecutive intervals stay within N +/- TOL.
module trig_period_meter
   import trig_period_meter_pkg::*;
#(
   parameter int N        = 10,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 4 * N
) (
   input  logic                CLK50MHZ,
   input  logic                RST,
   trig_period_meter_if.slave  bus
);
   localparam int W = flog2(TIMEOUT) + 1;
   localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT);

   meter_state_e state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] period_q, period_d;
   logic         pv_q, pv_d;
   logic         timeout_q, timeout_d;
   logic         strobe, to_hit, in_win;

   assign in_win = (int'(count_q) >= N - TOL) && (int'(count_q) <= N + TOL);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      period_d  = period_q;
      pv_d      = 1'b0;
      timeout_d = timeout_q;
      strobe    = 1'b0;
      to_hit    = 1'b0;
      case (state_q)
         WAIT_FIRST: begin
            if (bus.trig_in) begin
               state_d = MEASURE;
               count_d = W'(1);
            end
         end
         MEASURE: begin
            // a trigger on the timeout cycle still closes a valid interval
            if (bus.trig_in) begin
               period_d = count_q;
               pv_d     = 1'b1;
               strobe   = 1'b1;
               count_d  = W'(1);
            end else if (count_q == CNT_MAX) begin
               state_d   = TIMED_OUT;
               timeout_d = 1'b1;
               to_hit    = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         TIMED_OUT: begin
            if (bus.trig_in) begin
               state_d   = MEASURE;
               count_d   = W'(1);
               timeout_d = 1'b0;
            end
         end
         default: state_d = WAIT_FIRST;
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (!RST) begin
         state_q   <= WAIT_FIRST;
         count_q   <= '0;
         period_q  <= '0;
         pv_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         period_q  <= period_d;
         pv_q      <= pv_d;
         timeout_q <= timeout_d;
      end
   end

   lock_tracker #(.LOCK_CNT(LOCK_CNT)) u_lock (
      .clk_i    (CLK50MHZ),
      .rst_ni   (RST),
      .strobe_i (strobe),
      .in_win_i (in_win),
      .clr_i    (to_hit),
      .locked_o (bus.locked)
   );

   assign bus.period       = period_q;
   assign bus.period_valid = pv_q;
   assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_trig_period_meter.sv
// Randomized and directed bench for trig_period_meter against a trigger-time
// reference model (last trigger time, history of in-window flags).
module tb_trig_period_meter;
   import trig_period_meter_pkg::*;

   localparam int N   = 10;
   localparam int TOL = 1;
   localparam int LC  = 4;
   localparam int TO  = 40;
   localparam int W   = flog2(TO) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   trig_period_meter_if #(.W(W)) bus ();

   trig_period_meter #(.N(N), .TOL(TOL), .LOCK_CNT(LC), .TIMEOUT(TO)) dut (
      .CLK50MHZ (clk),
      .RST      (rst_n),
      .bus      (bus)
   );

   int tests = 0;
   int fails = 0;

   // reference model state
   int           cyc = 0;
   int           last_t = 0;
   bit           armed = 0;
   bit           hist[$];
   logic [W-1:0] m_period = '0;
   bit           m_pv = 0;
   bit           m_to = 0;

   function automatic bit m_locked();
      if (hist.size() < LC) return 1'b0;
      for (int i = hist.size() - LC; i < hist.size(); i++)
         if (!hist[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W+2:0] exp_vec();
      return {m_period, m_pv, m_locked(), m_to};
   endfunction

   function automatic logic [W+2:0] act_vec();
      return {bus.period, bus.period_valid, bus.locked, bus.timeout};
   endfunction

   // one clock: drive at negedge, advance model at posedge, settle 1 time unit
   task automatic tick(input bit trig, input bit rst);
      int gap;
      @(negedge clk);
      bus.trig_in = trig;
      rst_n = ~rst;
      @(posedge clk);
      cyc++;
      m_pv = 0;
      gap = cyc - last_t;
      if (rst) begin
         armed = 0; hist.delete(); m_period = '0; m_to = 0;
      end else if (trig) begin
         if (armed && gap <= TO) begin
            m_period = W'(gap);
            m_pv = 1;
            hist.push_back(gap >= N - TOL && gap <= N + TOL);
            if (hist.size() > LC) void'(hist.pop_front());
         end
         armed = 1; last_t = cyc; m_to = 0;
      end else if (armed && gap == TO) begin
         m_to = 1; armed = 0; hist.delete();
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(0, 1);
      tests++;
      if (act_vec() !== '0) begin
         fails++; $display("FAIL reset_state act=%h exp=%h", act_vec(), {(W+3){1'b0}});
      end
   endtask

   task automatic test_lock_basic();
      int ns, first_lock;
      ns = 0; first_lock = 0;
      tick(1, 0);
      tests++;
      if (bus.period_valid !== 1'b0) begin
         fails++; $display("FAIL first_trig_no_strobe act=%b exp=0", bus.period_valid);
      end
      for (int k = 0; k < 5; k++)
         for (int j = 1; j <= 10; j++) begin
            tick(j == 10, 0);
            tests++;
            if (act_vec() !== exp_vec()) begin
               fails++; $display("FAIL lock_basic cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.period_valid) begin
               ns++;
               if (bus.locked && first_lock == 0) first_lock = ns;
            end
         end
      tests++;
      if (ns != 5 || first_lock != 4) begin
         fails++; $display("FAIL lock_basic_count strobes=%0d lock_at=%0d exp 5/4", ns, first_lock);
      end
   endtask

   task automatic test_unlock_relock();
      for (int j = 1; j <= 13; j++) tick(j == 13, 0);
      tests++;
      if ({bus.period_valid, bus.period, bus.locked} !== {1'b1, W'(13), 1'b0}) begin
         fails++; $display("FAIL unlock_13 act pv=%b p=%0d lk=%b exp 1/13/0",
                           bus.period_valid, bus.period, bus.locked);
      end
      for (int k = 0; k < 4; k++)
         for (int j = 1; j <= 10; j++) begin
            tick(j == 10, 0);
            tests++;
            if (act_vec() !== exp_vec()) begin
               fails++; $display("FAIL relock cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
         end
      tests++;
      if (bus.locked !== 1'b1) begin
         fails++; $display("FAIL relock_final act=%b exp=1", bus.locked);
      end
   endtask

   task automatic test_window_edges();
      int gaps[5] = '{9, 11, 9, 11, 8};
      for (int k = 0; k < 5; k++) begin
         for (int j = 1; j <= gaps[k]; j++) begin
            tick(j == gaps[k], 0);
            tests++;
            if (act_vec() !== exp_vec()) begin
               fails++; $display("FAIL window cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
         end
         if (k == 3) begin
            tests++;
            if (bus.locked !== 1'b1) begin
               fails++; $display("FAIL window_lock act=%b exp=1", bus.locked);
            end
         end
      end
      tests++;
      if ({bus.period, bus.locked} !== {W'(8), 1'b0}) begin
         fails++; $display("FAIL window_8 act p=%0d lk=%b exp 8/0", bus.period, bus.locked);
      end
   endtask

   task automatic test_timeout();
      int npv;
      npv = 0;
      tick(1, 0);
      for (int j = 1; j <= 45; j++) begin
         tick(0, 0);
         if (bus.period_valid) npv++;
         tests++;
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL timeout cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
         end
      end
      tests++;
      if ({bus.timeout, bus.locked, npv[0]} !== 3'b100) begin
         fails++; $display("FAIL timeout_flag to=%b lk=%b npv=%0d exp 1/0/0", bus.timeout, bus.locked, npv);
      end
      tick(1, 0);
      tests++;
      if ({bus.timeout, bus.period_valid} !== 2'b00) begin
         fails++; $display("FAIL timeout_clear to=%b pv=%b exp 0/0", bus.timeout, bus.period_valid);
      end
      for (int j = 1; j <= 10; j++) tick(j == 10, 0);
      tests++;
      if ({bus.period_valid, bus.period} !== {1'b1, W'(10)}) begin
         fails++; $display("FAIL timeout_resume pv=%b p=%0d exp 1/10", bus.period_valid, bus.period);
      end
   endtask

   task automatic test_exact_timeout();
      for (int j = 1; j <= 40; j++) begin
         tick(j == 40, 0);
         tests++;
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL exact_to cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
         end
      end
      tests++;
      if ({bus.period_valid, bus.period, bus.timeout, bus.locked} !== {1'b1, W'(40), 1'b0, 1'b0}) begin
         fails++; $display("FAIL exact_to_40 pv=%b p=%0d to=%b lk=%b exp 1/40/0/0",
                           bus.period_valid, bus.period, bus.timeout, bus.locked);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++)
         for (int j = 1; j <= 10; j++) tick(j == 10, 0);
      tests++;
      if (bus.locked !== 1'b1) begin
         fails++; $display("FAIL rstmid_prelock act=%b exp=1", bus.locked);
      end
      for (int j = 0; j < 5; j++) tick(0, 0);
      tick(0, 1);
      tests++;
      if (act_vec() !== '0) begin
         fails++; $display("FAIL rstmid_zero act=%h exp=0", act_vec());
      end
      tick(0, 0);
      tick(0, 0);
      tick(1, 0);
      tests++;
      if (bus.period_valid !== 1'b0) begin
         fails++; $display("FAIL rstmid_first act=%b exp=0", bus.period_valid);
      end
      for (int j = 1; j <= 10; j++) tick(j == 10, 0);
      tests++;
      if ({bus.period_valid, bus.period} !== {1'b1, W'(10)}) begin
         fails++; $display("FAIL rstmid_second pv=%b p=%0d exp 1/10", bus.period_valid, bus.period);
      end
   endtask

   task automatic test_random();
      int pool[12] = '{1, 8, 9, 10, 10, 10, 11, 12, 15, 39, 40, 47};
      int g;
      for (int k = 0; k < 60; k++) begin
         g = pool[$urandom_range(11, 0)];
         for (int j = 1; j <= g; j++) begin
            tick(j == g, ($urandom_range(199, 0) == 0));
            tests++;
            if (act_vec() !== exp_vec()) begin
               fails++; $display("FAIL random cyc=%0d gap=%0d act=%h exp=%h", cyc, g, act_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.trig_in = 1'b0;
      test_reset();
      test_lock_basic();
      test_unlock_relock();
      test_window_edges();
      test_timeout();
      test_exact_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
